// File: rtl/prng_pkg.sv
// Shared definitions for the xorshift32 generator and its stream checker.
// Both sides call xorshift32_next() so the generator and checker cannot diverge.
package prng_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int unsigned DEF_SH_A = 13;
    localparam int unsigned DEF_SH_B = 17;
    localparam int unsigned DEF_SH_C = 5;

    // One xorshift32 step; shifts truncate to 32 bits.
    function automatic logic [31:0] xorshift32_next(
        input logic [31:0] x,
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        logic [31:0] y;
        y = x ^ (x << a);
        y = y ^ (y >> b);
        y = y ^ (y << c);
        return y;
    endfunction

endpackage

// File: rtl/prng_stream_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module prng_stream_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prng_stream_checker.sv
// Receive-side checker for the xorshift32 prng stream: syncs to the live
// stream, then flywheels its own model and flags every deviating word.
module prng_stream_checker
    import prng_pkg::*;
#(
    parameter int unsigned SH_A      = DEF_SH_A,
    parameter int unsigned SH_B      = DEF_SH_B,
    parameter int unsigned SH_C      = DEF_SH_C,
    parameter int unsigned CONFIRM_N = 4,
    parameter int unsigned LOSS_N    = 3,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             mismatch,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned RUN_W  = $clog2(CONFIRM_N + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_N + 1);

    state_t              state_q, state_d;
    logic [31:0]         model_q, model_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                locked_q, locked_d;
    logic                mismatch_q, mismatch_d;

    logic [31:0]         pred;
    logic [RUN_W-1:0]    run_inc;
    logic [MISS_W-1:0]   miss_inc;
    logic                word_inc;
    logic                err_inc;

    assign pred     = xorshift32_next(model_q, SH_A, SH_B, SH_C);
    assign run_inc  = run_q + 1'b1;
    assign miss_inc = miss_q + 1'b1;
    assign word_inc = din_valid && !clear;

    always_comb begin
        state_d    = state_q;
        model_d    = model_q;
        run_d      = run_q;
        miss_d     = miss_q;
        locked_d   = locked_q;
        mismatch_d = 1'b0;
        err_inc    = 1'b0;

        if (clear) begin
            state_d  = HUNT;
            model_d  = '0;
            run_d    = '0;
            miss_d   = '0;
            locked_d = 1'b0;
        end else if (din_valid) begin
            case (state_q)
                HUNT: begin
                    // Zero can never come out of xorshift, so it cannot seed.
                    if (din != '0) begin
                        model_d = din;
                        run_d   = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (din == pred) begin
                        model_d = din;
                        if (run_inc == RUN_W'(CONFIRM_N)) begin
                            run_d    = '0;
                            miss_d   = '0;
                            locked_d = 1'b1;
                            state_d  = LOCKED;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        model_d = din;
                        run_d   = '0;
                        if (din == '0) begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: advance on every valid word, never reseed from din.
                    model_d = pred;
                    if (din != pred) begin
                        mismatch_d = 1'b1;
                        err_inc    = 1'b1;
                        if (miss_inc == MISS_W'(LOSS_N)) begin
                            miss_d   = '0;
                            locked_d = 1'b0;
                            state_d  = HUNT;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            model_q    <= '0;
            run_q      <= '0;
            miss_q     <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            model_q    <= model_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
        end
    end

    prng_stream_counter #(
        .W (CNT_W)
    ) u_word_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear),
        .inc_i   (word_inc),
        .count_o (word_count)
    );

    prng_stream_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear),
        .inc_i   (err_inc),
        .count_o (err_count)
    );

    assign locked   = locked_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_prng_stream_checker.sv
// Randomized bench for prng_stream_checker against a behavioural stream model.
module tb_prng_stream_checker;

    localparam int unsigned CONFIRM_N = 4;
    localparam int unsigned LOSS_N    = 3;
    localparam int unsigned CNT_W     = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      din = '0;
    logic             din_valid = 1'b0;
    logic             clear = 1'b0;
    logic             locked;
    logic             mismatch;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model of the checker's observable behaviour.
    bit          m_seeded;
    bit          m_locked;
    bit          m_mm;
    logic [31:0] m_last;
    int unsigned m_good;
    int unsigned m_bad;
    logic [31:0] m_wc;
    logic [31:0] m_ec;

    logic [31:0] src;

    always #5 clk = ~clk;

    prng_stream_checker #(
        .SH_A      (13),
        .SH_B      (17),
        .SH_C      (5),
        .CONFIRM_N (CONFIRM_N),
        .LOSS_N    (LOSS_N),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .clear      (clear),
        .locked     (locked),
        .mismatch   (mismatch),
        .word_count (word_count),
        .err_count  (err_count)
    );

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] t;
        t = x;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seeded = 0;
        m_locked = 0;
        m_mm     = 0;
        m_last   = '0;
        m_good   = 0;
        m_bad    = 0;
        m_wc     = '0;
        m_ec     = '0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit c);
        logic [31:0] p;
        m_mm = 0;
        if (c) begin
            m_wc = '0; m_ec = '0;
            m_seeded = 0; m_locked = 0; m_good = 0; m_bad = 0;
        end else if (v) begin
            if (m_wc != 32'hFFFF_FFFF) m_wc++;
            p = xs(m_last);
            if (m_locked) begin
                m_last = p;
                if (d != p) begin
                    m_mm = 1;
                    if (m_ec != 32'hFFFF_FFFF) m_ec++;
                    m_bad++;
                    if (m_bad == LOSS_N) begin
                        m_locked = 0; m_seeded = 0; m_bad = 0;
                    end
                end else begin
                    m_bad = 0;
                end
            end else if (!m_seeded) begin
                if (d != 0) begin
                    m_last = d; m_seeded = 1; m_good = 0;
                end
            end else if (d == p) begin
                m_last = d;
                m_good++;
                if (m_good == CONFIRM_N) begin
                    m_locked = 1; m_good = 0; m_bad = 0;
                end
            end else begin
                m_last = d;
                m_good = 0;
                if (d == 0) m_seeded = 0;
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic apply(input bit v, input logic [31:0] d, input bit c);
        din_valid = v;
        din       = d;
        clear     = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check_val("locked",     32'(locked),   32'(m_locked));
        check_val("mismatch",   32'(mismatch), 32'(m_mm));
        check_val("word_count", word_count,    m_wc);
        check_val("err_count",  err_count,     m_ec);
        @(negedge clk);
        din_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic good_word();
        src = xs(src);
        apply(1'b1, src, 1'b0);
    endtask

    initial begin
        int unsigned r;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_mm",     32'(mismatch), 32'd0);
        check_val("rst_wc",     word_count, 32'd0);
        check_val("rst_ec",     err_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Seeded stream with literal first words.
        apply(1'b1, 32'h0000_0001, 1'b0);
        apply(1'b1, 32'h0004_2021, 1'b0);
        apply(1'b1, 32'h0408_0601, 1'b0);
        check_val("pre_lock", 32'(locked), 32'd0);
        src = 32'h0408_0601;
        repeat (2) good_word();
        check_val("lock5_locked", 32'(locked), 32'd1);
        check_val("lock5_wc", word_count, 32'd5);
        check_val("lock5_ec", err_count, 32'd0);

        // Single corruption.
        repeat (3) good_word();
        src = xs(src);
        apply(1'b1, src ^ 32'h1, 1'b0);
        check_val("corrupt_mm", 32'(mismatch), 32'd1);
        check_val("corrupt_ec", err_count, 32'd1);
        check_val("corrupt_locked", 32'(locked), 32'd1);
        repeat (5) good_word();

        // Idle gaps inside a locked stream.
        repeat (40) begin
            if ($urandom_range(2) == 0) apply(1'b0, $urandom, 1'b0);
            else good_word();
        end

        // clear with a valid word while locked.
        src = xs(src);
        apply(1'b1, src, 1'b1);
        check_val("clear_locked", 32'(locked), 32'd0);
        check_val("clear_wc", word_count, 32'd0);
        check_val("clear_ec", err_count, 32'd0);

        // Relock, then lose lock with LOSS_N corruptions.
        repeat (5) good_word();
        check_val("relock", 32'(locked), 32'd1);
        repeat (LOSS_N) begin
            src = xs(src);
            apply(1'b1, src ^ 32'h8000_0001, 1'b0);
        end
        check_val("loss_ec", err_count, 32'd3);
        check_val("loss_locked", 32'(locked), 32'd0);
        repeat (CONFIRM_N) good_word();
        check_val("relock_early", 32'(locked), 32'd0);
        good_word();
        check_val("relock_after_loss", 32'(locked), 32'd1);

        // Zero words then garbage.
        apply(1'b1, 32'h0, 1'b1);
        repeat (10) apply(1'b1, 32'h0, 1'b0);
        repeat (20) apply(1'b1, $urandom, 1'b0);
        check_val("garbage_wc", word_count, 32'd30);
        check_val("garbage_ec", err_count, 32'd0);
        check_val("garbage_locked", 32'(locked), 32'd0);

        // Random mix of all stimulus kinds.
        src = $urandom | 32'h1;
        repeat (300) begin
            r = $urandom_range(9);
            case (r)
                0:       apply(1'b0, $urandom, 1'b0);
                1:       begin src = xs(src); apply(1'b1, src ^ (32'h1 << $urandom_range(31)), 1'b0); end
                2:       apply(1'b1, $urandom, 1'b0);
                3:       apply(1'b1, 32'h0, 1'b0);
                default: good_word();
            endcase
        end

        // Async reset mid-stream, then relock timing.
        repeat (6) good_word();
        #2 rst = 1'b1;
        #1;
        check_val("arst_locked", 32'(locked), 32'd0);
        check_val("arst_mm",     32'(mismatch), 32'd0);
        check_val("arst_wc",     word_count, 32'd0);
        check_val("arst_ec",     err_count, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (CONFIRM_N) good_word();
        check_val("arst_early", 32'(locked), 32'd0);
        good_word();
        check_val("arst_relock", 32'(locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
